// File: rtl/zprize_mul_kara_pipe.sv
// zprize_mul_kara_pipe: one-level Karatsuba multiplier, W x W -> 2W bits.
// Four-stage elastic pipeline (operand/pre-sum, partial products, z1, final sum).
// Each stage has its own valid bit. A stage loads when it is empty or when its
// contents move on in the same cycle, so the pipe runs one beat per clock
// and stalls cleanly under output backpressure.
// mode_i[0] squares in0. mode_i[1] keeps only the low W bits when LOWONLY_EN is set.
module zprize_mul_kara_pipe #(
    parameter int W          = 384,
    parameter int M          = 32,
    parameter bit LOWONLY_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in0,
    input  logic [W-1:0]    in1,
    input  logic [1:0]      mode_i,
    input  logic [M-1:0]    m_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out0,
    output logic [M-1:0]    m_o
);

    localparam int W2 = W / 2;

    // stage valid bits and load strobes
    logic v0, v1, v2, v3;
    logic ld0, ld1, ld2, ld3, adv3;

    // S0: split operands and (W2+1)-bit pre-sums
    logic [W2-1:0] s0_x0, s0_x1, s0_y0, s0_y1;
    logic [W2:0]   s0_sx, s0_sy;
    logic          s0_lo;
    logic [M-1:0]  s0_m;

    // S1: partial products
    logic [W-1:0]  s1_m0, s1_m2;
    logic [W+1:0]  s1_m1;
    logic          s1_lo;
    logic [M-1:0]  s1_m;

    // S2: middle term
    logic [W-1:0]  s2_m0, s2_m2;
    logic [W+1:0]  s2_z1;
    logic          s2_lo;
    logic [M-1:0]  s2_m;

    // S3: result
    logic [2*W-1:0] s3_out;
    logic [M-1:0]   s3_m;

    // combinational helpers
    logic [W-1:0]   y_in;
    logic [W2:0]    sx_in, sy_in;
    logic [W-1:0]   m0_c, m2_c;
    logic [W+1:0]   m1_c, z1_c;
    logic [2*W-1:0] t_hi, t_mid, t_lo, full_c, res_c;

    // A stage frees up when its beat moves into the next stage during the same cycle.
    assign adv3     = v3 && out_ready;
    assign ld3      = v2 && (!v3 || adv3);
    assign ld2      = v1 && (!v2 || ld3);
    assign ld1      = v0 && (!v1 || ld2);
    assign in_ready = !rst && (!v0 || ld1);
    assign ld0      = in_valid && in_ready;

    assign out_valid = v3 && !rst;
    assign out0      = rst ? '0 : s3_out;
    assign m_o       = rst ? '0 : s3_m;

    // Square mode substitutes the multiplicand for the multiplier at the input.
    always_comb begin
        y_in  = mode_i[0] ? in0 : in1;
        sx_in = {1'b0, in0[W2-1:0]}  + {1'b0, in0[W-1:W2]};
        sy_in = {1'b0, y_in[W2-1:0]} + {1'b0, y_in[W-1:W2]};
    end

    // Partial products. Operands are zero-extended so each product is computed at full width.
    always_comb begin
        m0_c = {{W2{1'b0}}, s0_x0} * {{W2{1'b0}}, s0_y0};
        m2_c = {{W2{1'b0}}, s0_x1} * {{W2{1'b0}}, s0_y1};
        m1_c = {{(W2+1){1'b0}}, s0_sx} * {{(W2+1){1'b0}}, s0_sy};
    end

    // z1 = x0*y1 + x1*y0. It is always non-negative and fits in W+1 bits.
    always_comb begin
        z1_c = s1_m1 - {2'b00, s1_m2} - {2'b00, s1_m0};
    end

    // Recombination. The true sum never exceeds 2W bits, so truncation is exact.
    always_comb begin
        t_hi   = {s2_m2, {W{1'b0}}};
        t_mid  = {{(W-2){1'b0}}, s2_z1} << W2;
        t_lo   = {{W{1'b0}}, s2_m0};
        full_c = t_hi + t_mid + t_lo;
        res_c  = s2_lo ? {{W{1'b0}}, full_c[W-1:0]} : full_c;
    end

    // Valid bits: set on load, clear when the beat leaves with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld0)       v0 <= 1'b1;
            else if (ld1)  v0 <= 1'b0;
            if (ld1)       v1 <= 1'b1;
            else if (ld2)  v1 <= 1'b0;
            if (ld2)       v2 <= 1'b1;
            else if (ld3)  v2 <= 1'b0;
            if (ld3)       v3 <= 1'b1;
            else if (adv3) v3 <= 1'b0;
        end
    end

    // S0 capture: operands, pre-sums, effective low-half flag and metadata.
    always_ff @(posedge clk) begin
        if (ld0) begin
            s0_x0 <= in0[W2-1:0];
            s0_x1 <= in0[W-1:W2];
            s0_y0 <= y_in[W2-1:0];
            s0_y1 <= y_in[W-1:W2];
            s0_sx <= sx_in;
            s0_sy <= sy_in;
            s0_lo <= mode_i[1] & LOWONLY_EN;
            s0_m  <= m_i;
        end
    end

    // S1 capture: the three partial products.
    always_ff @(posedge clk) begin
        if (ld1) begin
            s1_m0 <= m0_c;
            s1_m2 <= m2_c;
            s1_m1 <= m1_c;
            s1_lo <= s0_lo;
            s1_m  <= s0_m;
        end
    end

    // S2 capture: middle term plus the outer products it needs later.
    always_ff @(posedge clk) begin
        if (ld2) begin
            s2_m0 <= s1_m0;
            s2_m2 <= s1_m2;
            s2_z1 <= z1_c;
            s2_lo <= s1_lo;
            s2_m  <= s1_m;
        end
    end

    // S3 capture: the result is held bit-stable until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_out <= '0;
            s3_m   <= '0;
        end else if (ld3) begin
            s3_out <= res_c;
            s3_m   <= s2_m;
        end
    end

endmodule

// File: tb/tb_zprize_mul_kara_pipe.sv
// Testbench for zprize_mul_kara_pipe.
// Contents: directed vectors with hand-computed products, backpressure fill,
// mid-stream reset, and a random stream scored against a plain wide multiply.
module tb_zprize_mul_kara_pipe;

    localparam int W  = 384;
    localparam int M  = 32;
    localparam int LW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in0, in1;
    logic [1:0]    mode_i;
    logic [M-1:0]  m_i;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out0;
    logic [M-1:0]  m_o;

    zprize_mul_kara_pipe #(.W(W), .M(M), .LOWONLY_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .mode_i    (mode_i),
        .m_i       (m_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .m_o       (m_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [LW-1:0] exp_q[$];
    logic [M-1:0]  meta_q[$];

    bit            have = 1'b0;
    logic [W-1:0]  cur_a, cur_b;
    logic [1:0]    cur_md;
    logic [M-1:0]  cur_mt;

    bit            mon_en = 1'b0;
    bit            hold_v = 1'b0;
    logic [LW-1:0] hold_o;
    logic [M-1:0]  hold_m;

    task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] md);
        logic [W-1:0]  bb;
        logic [LW-1:0] p;
        bb = md[0] ? a : b;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, bb};
        if (md[1]) p[LW-1:W] = '0;
        return p;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        case ($urandom_range(0, 7))
            0: r = '1;
            1: r[W-1:W/2] = '1;
            2: r[W/2-1:0] = '1;
            3: r = '0;
            4: r[W-1:8] = '0;
            default: ;
        endcase
        return r;
    endfunction

    task automatic new_beat();
        cur_a  = rand_op();
        cur_b  = rand_op();
        cur_md = 2'($urandom_range(0, 3));
        cur_mt = $urandom();
        have   = 1'b1;
    endtask

    // One clock of streaming: drive after the edge, record acceptance at the falling edge.
    task automatic step(input bit vld, input bit rdy);
        @(posedge clk); #1;
        out_ready = rdy;
        if (!have) new_beat();
        in_valid = vld;
        in0      = cur_a;
        in1      = cur_b;
        mode_i   = cur_md;
        m_i      = cur_mt;
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(model(cur_a, cur_b, cur_md));
            meta_q.push_back(cur_mt);
            have = 1'b0;
            n_acc++;
        end
    endtask

    // Single directed beat with exact latency check (accept edge + 3 further edges).
    task automatic send_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] md, input logic [M-1:0] mt,
                              input logic [LW-1:0] exp_out);
        int early;
        early = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in0 = a; in1 = b; mode_i = md; m_i = mt;
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, LW'(in_ready), LW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (out_valid) early++;
        end
        chk({tag, "_early_valid"}, LW'(early), LW'(0));
        @(posedge clk); #1;
        chk({tag, "_valid"}, LW'(out_valid), LW'(1));
        chk({tag, "_out0"}, out0, exp_out);
        chk({tag, "_meta"}, LW'(m_o), LW'(mt));
        @(posedge clk); #1;
        chk({tag, "_consumed"}, LW'(out_valid), LW'(0));
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [LW-1:0] e;
        logic [M-1:0]  mm;
        if (mon_en && !rst) begin
            if (hold_v) begin
                chk("stall_valid", LW'(out_valid), LW'(1));
                chk("stall_out0", out0, hold_o);
                chk("stall_meta", LW'(m_o), LW'(hold_m));
            end
            hold_v = out_valid && !out_ready;
            hold_o = out0;
            hold_m = m_o;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", LW'(out_valid), LW'(0));
                end else begin
                    e  = exp_q.pop_front();
                    mm = meta_q.pop_front();
                    chk("prod", out0, e);
                    chk("meta", LW'(m_o), LW'(mm));
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        logic [LW-1:0] e_max;
        int            seen;
        int            guard;

        rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; mode_i = '0; m_i = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", LW'(in_ready), LW'(0));
        chk("rst_out_valid", LW'(out_valid), LW'(0));
        chk("rst_out0", out0, '0);
        chk("rst_m_o", LW'(m_o), LW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", LW'(in_ready), LW'(1));

        // Directed vectors.
        e_max = {LW{1'b1}} - (LW'(1) << (W + 1)) + LW'(2);
        send_check("max_x_max", '1, '1, 2'd0, 32'hA5, e_max);
        send_check("square_3", W'(3), W'(5), 2'd1, 32'h11, LW'(9));
        send_check("low_2p383_x2", W'(1) << (W - 1), W'(2), 2'd2, 32'h22, '0);
        send_check("low_max_x_max", '1, '1, 2'd2, 32'h33, LW'(1));
        send_check("low_square_max", '1, W'(0), 2'd3, 32'h44, LW'(1));
        send_check("square_max", '1, W'(7), 2'd1, 32'h55, e_max);
        send_check("half_x_half", W'(1) << (W / 2), W'(1) << (W / 2), 2'd0, 32'h66,
                   LW'(1) << W);

        // Backpressure: the pipe holds exactly four beats, then everything drains in order.
        mon_en = 1'b1;
        n_acc  = 0;
        repeat (8) step(1'b1, 1'b0);
        chk("bp_accepts", LW'(n_acc), LW'(4));
        chk("bp_in_ready", LW'(in_ready), LW'(0));
        guard = 0;
        while (n_acc < 8 && guard < 50) begin
            step(1'b1, 1'b1);
            guard++;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("bp_total", LW'(n_acc), LW'(8));
        chk("bp_drain", LW'(exp_q.size()), LW'(0));

        // Full throughput: sixteen beats in sixteen consecutive cycles.
        n_acc = 0;
        repeat (16) step(1'b1, 1'b1);
        chk("thru_accepts", LW'(n_acc), LW'(16));
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, 1'b1);
            guard++;
        end
        chk("thru_drain", LW'(exp_q.size()), LW'(0));

        // Mid-stream reset discards in-flight beats.
        mon_en = 1'b0;
        n_acc  = 0;
        repeat (3) step(1'b1, 1'b0);
        chk("mr_accepts", LW'(n_acc), LW'(3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_in_ready_low", LW'(in_ready), LW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        meta_q.delete();
        @(negedge clk);
        chk("mr_in_ready", LW'(in_ready), LW'(1));
        chk("mr_out_valid", LW'(out_valid), LW'(0));
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mr_no_ghost", LW'(seen), LW'(0));
        send_check("mr_fresh", W'(12345), W'(678), 2'd0, 32'h77, LW'(12345 * 678));

        // Random soak: random modes, valid and ready.
        mon_en = 1'b1;
        have   = 1'b0;
        n_acc  = 0;
        for (int c = 0; c < 30000 && (n_acc < 2000 || exp_q.size() != 0); c++) begin
            step((n_acc < 2000) && ($urandom_range(0, 99) < 70), $urandom_range(0, 99) < 60);
        end
        chk("soak_accepts", LW'(n_acc), LW'(2000));
        chk("soak_drain", LW'(exp_q.size()), LW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
